// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad door lock controller.
//   A code is entered as ps_start, a series of ps_valid digits, then ps_end.
//   The entry is checked in a single CHECK cycle and either opens the door for
//   OPEN_CYCLES, flags one error cycle, or, after MAX_FAIL consecutive
//   failures, locks the keypad out for LOCK_CYCLES.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ps_start          begin (or restart) an entry
//   ps_num/ps_valid   digit value and its qualifier
//   ps_end            end of entry, request check
//   door_open         registered, high only in OPEN
//   state_out         registered state code (IDLE=0 .. LOCK=5)
//   fail_cnt          consecutive failure count
//   err               registered, high only in FAIL
//   lockout           registered, high only in LOCK
module doorlock_ctrl #(
    parameter int                          PW_LEN      = 4,
    parameter int                          DIGIT_W     = 4,
    parameter logic [PW_LEN*DIGIT_W-1:0]   PASSWORD    = 16'h1234,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          OPEN_CYCLES = 16,
    parameter int                          LOCK_CYCLES = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps_start,
    input  logic [DIGIT_W-1:0]              ps_num,
    input  logic                            ps_valid,
    input  logic                            ps_end,
    output logic                            door_open,
    output logic [2:0]                      state_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic                            err,
    output logic                            lockout
);

    localparam int BW   = PW_LEN * DIGIT_W;
    localparam int CW   = $clog2(PW_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_CHECK = 3'd2,
        S_OPEN  = 3'd3,
        S_FAIL  = 3'd4,
        S_LOCK  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [TW-1:0]   tmr_q, tmr_d;      // shared by OPEN and LOCK, never both live
    logic [FW-1:0]   fail_q, fail_d;
    logic            door_q, err_q, lock_q;
    logic            match;
    logic [FW:0]     fail_inc;          // one bit wider so +1 cannot wrap

    assign match    = (cnt_q == CW'(PW_LEN)) && !ovf_q && (buf_q == PASSWORD);
    assign fail_inc = {1'b0, fail_q} + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        buf_d   = buf_q;
        tmr_d   = tmr_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (ps_start) begin
                    state_d = S_ENTRY;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    buf_d   = '0;
                end
            end
            S_ENTRY: begin
                // ps_end wins over ps_start and ps_valid in the same cycle
                if (ps_end) begin
                    state_d = S_CHECK;
                end else if (ps_start) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    buf_d = '0;
                end else if (ps_valid) begin
                    if (cnt_q < CW'(PW_LEN)) begin
                        buf_d = (buf_q << DIGIT_W) | BW'(ps_num);
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (match) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                    tmr_d   = TW'(OPEN_CYCLES - 1);
                end else if (fail_inc < (FW+1)'(MAX_FAIL)) begin
                    state_d = S_FAIL;
                    fail_d  = fail_inc[FW-1:0];
                end else begin
                    state_d = S_LOCK;
                    fail_d  = FW'(MAX_FAIL);
                    tmr_d   = TW'(LOCK_CYCLES - 1);
                end
            end
            S_OPEN: begin
                if (tmr_q == '0) state_d = S_IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            S_LOCK: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            buf_q   <= '0;
            tmr_q   <= '0;
            fail_q  <= '0;
            door_q  <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            buf_q   <= buf_d;
            tmr_q   <= tmr_d;
            fail_q  <= fail_d;
            // flags decoded from the next state so they align with state_q
            door_q  <= (state_d == S_OPEN);
            err_q   <= (state_d == S_FAIL);
            lock_q  <= (state_d == S_LOCK);
        end
    end

    assign door_open = door_q;
    assign err       = err_q;
    assign lockout   = lock_q;
    assign state_out = state_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Scoreboard bench for doorlock_ctrl: stimulus pushes the expected outcome
// of each entry; a negedge monitor pops it when door_open/err/lockout rises
// and then measures how long the output stays high.
module tb_doorlock_ctrl;

    typedef struct {
        logic [2:0] st;        // state code when the output rises
        logic [1:0] fc;        // fail_cnt when the output rises
        int         dur;       // cycles output stays high (0 = not checked)
        logic [1:0] fc_after;  // fail_cnt once back in IDLE
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4, rst6, sel;
    logic       ps_start, ps_valid, ps_end;
    logic [3:0] ps_num;

    logic       d4_open, d4_err, d4_lock, d6_open, d6_err, d6_lock;
    logic [2:0] d4_st, d6_st;
    logic [1:0] d4_fc, d6_fc;

    logic       m_open, m_err, m_lock;
    logic [2:0] m_st;
    logic [1:0] m_fc;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t mon_cur;
    bit   mon_active = 1'b0;
    int   mon_run = 0;
    logic [2:0] prev_st = 3'd0;

    always #5 clk = ~clk;

    doorlock_ctrl u_dut4 (
        .clk(clk), .rst(rst4), .ps_start(ps_start), .ps_num(ps_num),
        .ps_valid(ps_valid), .ps_end(ps_end), .door_open(d4_open),
        .state_out(d4_st), .fail_cnt(d4_fc), .err(d4_err), .lockout(d4_lock)
    );

    doorlock_ctrl #(.PW_LEN(6), .DIGIT_W(4), .PASSWORD(24'h909090)) u_dut6 (
        .clk(clk), .rst(rst6), .ps_start(ps_start), .ps_num(ps_num),
        .ps_valid(ps_valid), .ps_end(ps_end), .door_open(d6_open),
        .state_out(d6_st), .fail_cnt(d6_fc), .err(d6_err), .lockout(d6_lock)
    );

    assign m_open = sel ? d6_open : d4_open;
    assign m_err  = sel ? d6_err  : d4_err;
    assign m_lock = sel ? d6_lock : d4_lock;
    assign m_st   = sel ? d6_st   : d4_st;
    assign m_fc   = sel ? d6_fc   : d4_fc;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!mon_active) begin
            if (m_open || m_err || m_lock) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_cur = q.pop_front();
                    chk("out_kind", {m_open, m_err, m_lock},
                        (mon_cur.st == 3'd3) ? 4 : (mon_cur.st == 3'd4) ? 2 : 1);
                    chk("out_state", m_st, mon_cur.st);
                    chk("out_fail_cnt", m_fc, mon_cur.fc);
                    chk("prev_state_check", prev_st, 2);
                    mon_active = 1'b1;
                    mon_run    = 1;
                end
            end
        end else if (m_open || m_err || m_lock) begin
            mon_run++;
        end else begin
            if (mon_cur.dur != 0) chk("out_duration", mon_run, mon_cur.dur);
            chk("after_state_idle", m_st, 0);
            chk("after_fail_cnt", m_fc, mon_cur.fc_after);
            mon_active = 1'b0;
        end
        prev_st = m_st;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ps_start = 1'b1; tick(); ps_start = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        ps_num = d; ps_valid = 1'b1; tick(); ps_valid = 1'b0;
    endtask

    task automatic pend();
        ps_end = 1'b1; tick(); ps_end = 1'b0;
        chk("latency_check_state", m_st, 2);
    endtask

    task automatic expect_out(input int st, input int fc, input int dur, input int fca);
        exp_t e;
        e.st = 3'(st); e.fc = 2'(fc); e.dur = dur; e.fc_after = 2'(fca);
        q.push_back(e);
    endtask

    // start, n digits of code (MS digit first), end
    task automatic enter(input logic [31:0] code, input int n);
        pulse_start();
        for (int i = 0; i < n; i++) digit(code[4*(n-1-i) +: 4]);
        pend();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((q.size() != 0 || mon_active || m_st != 3'd0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            chk({name, "_timeout"}, n, 0);
            q.delete();
            mon_active = 1'b0;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_state"}, m_st, 0);
        chk({name, "_outs"}, {m_open, m_err, m_lock}, 0);
        chk({name, "_fail_cnt"}, m_fc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst4 = 1'b1; rst6 = 1'b1; sel = 1'b0;
        ps_start = 1'b0; ps_valid = 1'b0; ps_end = 1'b0; ps_num = 4'd0;
        tick(); tick();
        chk_zero("reset_held");
        rst4 = 1'b0;
        tick();
        chk_zero("reset_released");

        // correct code
        expect_out(3, 0, 16, 0); enter(32'h1234, 4); wait_done("open1");
        // short code, then overflow
        expect_out(4, 1, 1, 1); enter(32'h123, 3); wait_done("short");
        expect_out(4, 2, 1, 2); enter(32'h12345, 5); wait_done("overflow");
        // third consecutive failure locks; keypad ignored while locked
        expect_out(5, 3, 32, 0); enter(32'h9999, 4);
        tick(); tick();
        pulse_start(); digit(4'h1); digit(4'h2); pend_ignored();
        wait_done("lock");

        // two failures then success; second failure drops a digit on ps_end
        expect_out(4, 1, 1, 1); enter(32'h5555, 4); wait_done("fail_a");
        expect_out(4, 2, 1, 2);
        pulse_start(); digit(4'h1); digit(4'h2); digit(4'h3);
        ps_num = 4'h4; ps_valid = 1'b1; ps_end = 1'b1; tick();
        ps_valid = 1'b0; ps_end = 1'b0;
        chk("drop_digit_check_state", m_st, 2);
        wait_done("drop_digit");
        expect_out(3, 0, 16, 0); enter(32'h1234, 4); wait_done("open_clears");

        // restart mid-entry via ps_start
        expect_out(3, 0, 16, 0);
        pulse_start(); digit(4'h9); digit(4'h9);
        enter(32'h1234, 4); wait_done("restart");

        // reset mid-ENTRY with a nonzero fail count
        expect_out(4, 1, 1, 1); enter(32'h7, 1); wait_done("fail_pre_rst");
        pulse_start(); digit(4'h1); digit(4'h2);
        rst4 = 1'b1; #1;
        chk_zero("rst_mid_entry");
        tick();
        rst4 = 1'b0; ps_start = 1'b1; tick(); ps_start = 1'b0;
        chk("first_start_after_rst", m_st, 1);

        // reset mid-OPEN
        expect_out(3, 0, 0, 0);
        digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4); pend();
        tick(); tick(); tick();
        rst4 = 1'b1; #1;
        chk_zero("rst_mid_open");
        tick();
        rst4 = 1'b0;
        wait_done("rst_open");
        expect_out(3, 0, 16, 0); enter(32'h1234, 4); wait_done("open_after_rst");

        // six-digit instance
        rst4 = 1'b1; sel = 1'b1; rst6 = 1'b0;
        tick();
        chk_zero("six_reset");
        expect_out(3, 0, 16, 0); enter(32'h909090, 6); wait_done("six_open");
        expect_out(4, 1, 1, 1); enter(32'h9090, 4); wait_done("six_short");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ps_end while locked: the state must stay LOCK, not CHECK
    task automatic pend_ignored();
        ps_end = 1'b1; tick(); ps_end = 1'b0;
        chk("lock_ignores_inputs", m_st, 5);
    endtask

endmodule
